// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 2;
  localparam int CMD_W  = 4;
  localparam int FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ARITH = 2'd0;
  localparam logic [OP_W-1:0] OP_LOGIC = 2'd1;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    EXEC = 3'b010,
    RESP = 3'b100
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the execute stage (r0) and
// the address/PC path (r1): accept, one registered EXEC cycle, held response.
module alu_arbiter #(
  parameter int DATA_W = alu_arb_pkg::DATA_W,
  parameter int OP_W   = alu_arb_pkg::OP_W,
  parameter int CMD_W  = alu_arb_pkg::CMD_W,
  parameter int FLAG_W = alu_arb_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic [OP_W-1:0]   r0_req_opcode,
  input  logic [CMD_W-1:0]  r0_req_cmd,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  input  logic [OP_W-1:0]   r1_req_opcode,
  input  logic [CMD_W-1:0]  r1_req_cmd,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [CMD_W-1:0]  alu_cmd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              busy
);

  import alu_arb_pkg::*;

  state_t state, state_nxt;

  logic              rr_ptr;
  logic              owner;
  logic [1:0]        grant;
  logic              accept;
  logic              rsp_fire;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0]   op_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [FLAG_W-1:0] flags_q;

  rr_arb2 u_rr_arb2 (
    .req   ({r1_req_valid, r0_req_valid}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs are gated with rst_n so nothing is accepted or
  // consumed in a cycle whose transaction reset is about to discard.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    rsp_fire     = 1'b0;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    busy         = (state != IDLE);
    unique case (state)
      IDLE: begin
        r0_req_ready = rst_n && grant[0];
        r1_req_ready = rst_n && grant[1];
        accept       = |grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        r0_rsp_valid = rst_n && !owner;
        r1_rsp_valid = rst_n && owner;
        rsp_fire     = owner ? r1_rsp_ready : r0_rsp_ready;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cmd_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        owner <= grant[1];
        a_q   <= grant[1] ? r1_req_a      : r0_req_a;
        b_q   <= grant[1] ? r1_req_b      : r0_req_b;
        op_q  <= grant[1] ? r1_req_opcode : r0_req_opcode;
        cmd_q <= grant[1] ? r1_req_cmd    : r0_req_cmd;
      end
      if (state == EXEC) begin
        res_q   <= alu_out;
        flags_q <= alu_flags;
      end
      if (rsp_fire) rr_ptr <= ~owner;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_cmd    = cmd_q;
  assign rsp_out    = res_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU behind the alu_* ports.
module tb_alu_arbiter;

  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
  logic [31:0] r0_req_a, r0_req_b;
  logic [1:0]  r0_req_opcode;
  logic [3:0]  r0_req_cmd;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [31:0] r1_req_a, r1_req_b;
  logic [1:0]  r1_req_opcode;
  logic [3:0]  r1_req_cmd;
  logic [31:0] rsp_out, alu_a, alu_b, alu_out;
  logic [3:0]  rsp_flags, alu_cmd, alu_flags;
  logic [1:0]  alu_opcode;
  logic        busy;
  logic        alu_carry;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_req_a(r0_req_a), .r0_req_b(r0_req_b),
    .r0_req_opcode(r0_req_opcode), .r0_req_cmd(r0_req_cmd),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_req_a(r1_req_a), .r1_req_b(r1_req_b),
    .r1_req_opcode(r1_req_opcode), .r1_req_cmd(r1_req_cmd),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cmd(alu_cmd),
    .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
  );

  // ALU: arith cmd 1 add, 2 sub (carry = borrow), 3 shl, 4 shr; logic cmd[1:0] and/or/xor/not-a.
  // Flags are {negative, zero, carry, 0}.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    if (alu_opcode == OP_ARITH) begin
      case (alu_cmd)
        4'd1: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        4'd2: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
        4'd3: alu_out = alu_a << alu_b[4:0];
        4'd4: alu_out = alu_a >> alu_b[4:0];
        default: alu_out = '0;
      endcase
    end else if (alu_opcode == OP_LOGIC) begin
      case (alu_cmd[1:0])
        2'd0: alu_out = alu_a & alu_b;
        2'd1: alu_out = alu_a | alu_b;
        2'd2: alu_out = alu_a ^ alu_b;
        default: alu_out = ~alu_a;
      endcase
    end
    alu_flags = {alu_out[31], (alu_out == 32'd0), alu_carry, 1'b0};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? r0_req_ready : r1_req_ready;
  endfunction

  function automatic logic rvld(input int p);
    return (p == 0) ? r0_rsp_valid : r1_rsp_valid;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] cmd);
    if (p == 0) begin
      r0_req_a = a; r0_req_b = b; r0_req_opcode = op; r0_req_cmd = cmd; r0_req_valid = 1'b1;
    end else begin
      r1_req_a = a; r1_req_b = b; r1_req_opcode = op; r1_req_cmd = cmd; r1_req_valid = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) r0_req_valid = 1'b0;
    else        r1_req_valid = 1'b0;
  endtask

  // Waits for port p's ready, completes the handshake, drops valid; rc = ready cycle.
  task automatic await_ready(input int p, output int rc);
    rc = -1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (rdy(p)) begin
        rc = cyc;
        chk("other_req_ready_low", rdy(1 - p), 1'b0);
        @(posedge clk); #1;
        drop(p);
        break;
      end
      @(posedge clk);
    end
    if (rc < 0) drop(p);
    chk("req_ready_seen", rc >= 0, 1'b1);
  endtask

  // Waits for port p's response (rsp_ready held high), checks it, steps past the handshake.
  task automatic expect_rsp(input int p, input logic [31:0] exp_out, input logic [3:0] exp_flags,
                            input int rc);
    int found = -1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (rvld(p)) begin found = cyc; break; end
      @(posedge clk);
    end
    chk("rsp_valid_seen", found >= 0, 1'b1);
    chk("rsp_latency", found - rc, 2);
    chk("rsp_out", rsp_out, exp_out);
    chk("rsp_flags", rsp_flags, exp_flags);
    chk("other_rsp_valid_low", rvld(1 - p), 1'b0);
    @(posedge clk); #1;
    chk("idle_after_rsp", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int rc, prev_rc;

  initial begin
    rst_n = 1'b0;
    r0_req_valid = 0; r0_req_a = 0; r0_req_b = 0; r0_req_opcode = 0; r0_req_cmd = 0; r0_rsp_ready = 1;
    r1_req_valid = 0; r1_req_a = 0; r1_req_b = 0; r1_req_opcode = 0; r1_req_cmd = 0; r1_rsp_ready = 1;

    // Reset state, with r0 already requesting: nothing may be accepted yet.
    do_reset();
    set_req(0, 32'h11111, 32'h00111, 2'd0, 4'd1);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_r0_req_ready", r0_req_ready, 1'b0);
    chk("rst_r1_req_ready", r1_req_ready, 1'b0);
    chk("rst_r0_rsp_valid", r0_rsp_valid, 1'b0);
    chk("rst_r1_rsp_valid", r1_rsp_valid, 1'b0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;

    // 1: single r0 request
    await_ready(0, rc);
    chk("t1_exec_busy", busy, 1'b1);
    chk("t1_ready_pulse", r0_req_ready, 1'b0);
    expect_rsp(0, 32'h11222, 4'b0000, rc);

    // 2: contention from reset, then alternation against a fresh r0 request
    do_reset();
    rst_n = 1'b1;
    set_req(0, 32'd5, 32'd7, 2'd0, 4'd2);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 2'd0, 4'd1);
    await_ready(0, rc);
    expect_rsp(0, 32'hFFFF_FFFE, 4'b1010, rc);
    set_req(0, 32'd3, 32'd4, 2'd1, 4'b1001);
    await_ready(1, rc);
    expect_rsp(1, 32'd0, 4'b0110, rc);
    await_ready(0, rc);
    expect_rsp(0, 32'd7, 4'b0000, rc);

    // 3: r1 backpressure, r0 requesting meanwhile
    r1_rsp_ready = 1'b0;
    set_req(1, 32'h10011, 32'h00101, 2'd1, 4'd0);
    await_ready(1, rc);
    @(posedge clk); #1;
    chk("t3_rsp_latency", cyc - rc, 2);
    set_req(0, 32'h100, 32'h23, 2'd0, 4'd1);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_r1_rsp_valid", r1_rsp_valid, 1'b1);
      chk("t3_rsp_out", rsp_out, 32'h1);
      chk("t3_rsp_flags", rsp_flags, 4'b0000);
      chk("t3_busy", busy, 1'b1);
      chk("t3_r0_req_ready", r0_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    r1_rsp_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    chk("t3_idle_after_release", busy, 1'b0);
    chk("t3_r1_rsp_cleared", r1_rsp_valid, 1'b0);

    // 4: operand isolation on the queued r0 request
    await_ready(0, rc);
    r0_req_a = 32'hDEAD_BEEF;
    #1;
    chk("t4_alu_a_held", alu_a, 32'h100);
    chk("t4_alu_b_held", alu_b, 32'h23);
    expect_rsp(0, 32'h123, 4'b0000, rc);

    // 5: reset during EXEC discards the op; r1 is served afterwards
    set_req(0, 32'd7, 32'd7, 2'd0, 4'd2);
    await_ready(0, rc);
    rst_n = 1'b0;
    set_req(1, 32'd1, 32'd4, 2'd0, 4'd3);
    @(posedge clk); #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_r0_rsp_valid", r0_rsp_valid, 1'b0);
    chk("t5_r1_rsp_valid", r1_rsp_valid, 1'b0);
    chk("t5_r1_req_ready", r1_req_ready, 1'b0);
    chk("t5_rsp_out", rsp_out, 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    chk("t5_r0_rsp_valid_2", r0_rsp_valid, 1'b0);
    rst_n = 1'b1;
    await_ready(1, rc);
    expect_rsp(1, 32'h10, 4'b0000, rc);

    // 6: back-to-back cmd sweep on r0
    set_req(0, 32'hF0, 32'h10, 2'd0, 4'd1);
    await_ready(0, rc);
    expect_rsp(0, 32'h100, 4'b0000, rc);
    prev_rc = rc;
    set_req(0, 32'hF0, 32'h10, 2'd0, 4'd2);
    await_ready(0, rc);
    chk("t6_spacing_sub", rc - prev_rc, 3);
    expect_rsp(0, 32'hE0, 4'b0000, rc);
    prev_rc = rc;
    set_req(0, 32'hF0, 32'h10, 2'd0, 4'd3);
    await_ready(0, rc);
    chk("t6_spacing_shl", rc - prev_rc, 3);
    expect_rsp(0, 32'h00F0_0000, 4'b0000, rc);
    prev_rc = rc;
    set_req(0, 32'hF0, 32'h10, 2'd0, 4'd4);
    await_ready(0, rc);
    chk("t6_spacing_shr", rc - prev_rc, 3);
    expect_rsp(0, 32'h0, 4'b0100, rc);
    prev_rc = rc;
    set_req(0, 32'hF0, 32'h10, 2'd1, 4'b1010);
    await_ready(0, rc);
    chk("t6_spacing_xor", rc - prev_rc, 3);
    expect_rsp(0, 32'hE0, 4'b0000, rc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
